hazard_fwd_unit: RTL
====================

Name: hazard_fwd_unit

Overview:
- Tracks destination-register tags of in-flight instructions through the EX, MEM and WB stages.
- Drives the 2-bit select lines of the two EX-stage 3:1 operand muxes (ALU src A/B forwarding).
- Raises a one-cycle load-use stall and inserts the matching bubble.
- Sits beside the ID/EX boundary: consumes decoded ID-stage fields, feeds the forwarding muxes, PC write enable and IF/ID write enable.

Parameters:
REG_AW, 5, register-address width
CNT_W, 16, width of optional stall counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
id_valid_i  in  1  ID holds a real instruction
id_rs_i  in  REG_AW  ID source register 1
id_rt_i  in  REG_AW  ID source register 2
id_rd_i  in  REG_AW  ID destination register (already muxed rt/rd)
id_regwrite_i  in  1  ID instruction writes the register file
id_memread_i  in  1  ID instruction is a load
flush_i  in  1  branch/jump taken; discard the ID instruction
fwd_a_o  out  2  operand-A mux select for the EX stage
fwd_b_o  out  2  operand-B mux select for the EX stage
stall_o  out  1  load-use stall this cycle
pc_write_o  out  1  equals ~stall_o
ifid_write_o  out  1  equals ~stall_o

Behaviour:
- Internal slots, all registered:
  - EX: valid, rs, rt, rd, regwrite, memread
  - MEM: valid, rd, regwrite
  - WB: valid, rd, regwrite
- Reset (synchronous, rst_i=1 at a rising edge): all slot valid bits cleared.
  - Outputs after reset: fwd_a_o=fwd_b_o=2'b00, stall_o=0, pc_write_o=ifid_write_o=1.
  - Reset overrides stall and flush in the same cycle.
- Every cycle: WB<=MEM and MEM<=EX, unconditionally.
- EX capture:
  - EX<=ID fields when id_valid_i & ~stall_o & ~flush_i.
  - Otherwise EX.valid<=0 (bubble).
- Select encoding:
  - 00 = ID/EX register-file value
  - 01 = EX/MEM ALU result
  - 10 = MEM/WB write-back value
  - 11 is never driven.
- fwd_a_o, combinational from slot registers only; no dependency on ID inputs:
  - 01 if MEM.valid & MEM.regwrite & MEM.rd!=0 & MEM.rd==EX.rs
  - else 10 if WB.valid & WB.regwrite & WB.rd!=0 & WB.rd==EX.rs
  - else 00
  - MEM has priority over WB (youngest producer wins).
- fwd_b_o: same rule using EX.rt.
- Either select is 00 whenever EX.valid=0.
- Register 0 is never forwarded and never causes a stall.
- stall_o, combinational:
  - 1 when EX.valid & EX.memread & EX.rd!=0 & id_valid_i & ~flush_i & (EX.rd==id_rs_i | EX.rd==id_rt_i).
  - Lasts exactly one cycle: the next cycle EX holds the bubble, so the condition clears.
  - The load then sits in MEM and is forwarded 10 one cycle later, once it reaches WB.
- Simultaneous flush_i and load-use: flush wins, stall_o=0, bubble inserted.
- Back-to-back loads to the same register with a dependent consumer: one stall per load, never more than one consecutive stall cycle.
- ID-vs-WB same-cycle hazards are not this block's job; the register file writes first and reads second.
- Latency: selects are valid in the same cycle the consumer occupies EX.
- Stall is combinational within the ID cycle.

Optional Feature:
- Macro HAZ_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt_o [CNT_W-1:0].
  - Increments on every cycle with stall_o=1.
  - Saturates at all-ones; cleared by rst_i.
- When undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package hazard_pkg holds:
  - FWD_REGFILE=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10
  - REG_AW default
  - packed slot typedef (valid, rd, regwrite, plus rs, rt, memread for EX)
- One natural sub-module: fwd_sel, combinational compare-and-prioritise for a single operand.
  - Instantiated twice, for A and B.

Test Plan:
- Reset then idle: rst_i=1 one cycle, no valid ID → fwd_a_o=fwd_b_o=00, stall_o=0, pc_write_o=1.
- EX→EX forward: add $3 then sub $5,$3,$4 next cycle → when sub in EX, fwd_a_o=01, fwd_b_o=00.
- MEM→EX forward with priority: add $3, add $3, or $6,$3,$3 → fwd_a_o=fwd_b_o=01 (youngest); with a nop between the producer and the or instead → 10.
- Load-use: lw $2 followed by add $4,$2,$1:
  - stall_o=1 for exactly one cycle, pc_write_o=ifid_write_o=0.
  - EX gets a bubble; next cycle the add enters EX with fwd_a_o=10.
- $0 destination: addi $0 then add $7,$0,$0 → selects 00; lw $0 then use of $0 → no stall.
- Flush vs stall: lw $2, ID holds a consumer of $2, flush_i=1 same cycle:
  - stall_o=0, EX bubble; no forwarding next cycle.
  - With HAZ_STALL_CNT_EN, stall_cnt_o stays unchanged.

Source files
------------

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
//
// Shared types and constants for the hazard / forwarding unit.
//
//   REG_AW_DEFAULT  default register-address width (MIPS-style, 32 registers)
//   CNT_W_DEFAULT   default width of the optional stall counter
//   fwd_sel_e       2-bit select for the EX-stage 3:1 operand muxes
//   ex_slot_t       EX-stage tag slot (needs source tags and the load flag)
//   pipe_slot_t     MEM / WB tag slot (destination tag only)
//   slot_writes_reg helper: slot holds a live producer of a non-zero register
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam int REG_AW_DEFAULT = 5;
  localparam int CNT_W_DEFAULT  = 16;

  // Operand-mux select. 2'b11 is deliberately left unencoded.
  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,  // value read from the register file in ID
    FWD_EXMEM   = 2'b01,  // ALU result sitting in EX/MEM
    FWD_MEMWB   = 2'b10   // write-back value sitting in MEM/WB
  } fwd_sel_e;

  typedef struct packed {
    logic                      valid;
    logic [REG_AW_DEFAULT-1:0] rs;
    logic [REG_AW_DEFAULT-1:0] rt;
    logic [REG_AW_DEFAULT-1:0] rd;
    logic                      regwrite;
    logic                      memread;
  } ex_slot_t;

  typedef struct packed {
    logic                      valid;
    logic [REG_AW_DEFAULT-1:0] rd;
    logic                      regwrite;
  } pipe_slot_t;

  // Register 0 is hard-wired to zero, so a "write" to it produces nothing
  // worth forwarding.
  function automatic logic slot_writes_reg(input pipe_slot_t s);
    return s.valid & s.regwrite & (s.rd != '0);
  endfunction

endpackage : hazard_pkg

// File: rtl/fwd_sel.sv
// -----------------------------------------------------------------------------
// fwd_sel
//
// Compare-and-prioritise logic for one EX-stage source operand. Purely
// combinational; instantiated once for ALU operand A and once for B.
//
// Ports:
//   ex_valid_i  EX slot holds a real instruction
//   src_i       source register tag of the EX instruction for this operand
//   mem_i       MEM slot (older by one instruction)
//   wb_i        WB slot  (older by two instructions)
//   sel_o       operand-mux select (hazard_pkg::fwd_sel_e encoding)
// -----------------------------------------------------------------------------
module fwd_sel
  import hazard_pkg::*;
(
  input  logic                      ex_valid_i,
  input  logic [REG_AW_DEFAULT-1:0] src_i,
  input  pipe_slot_t                mem_i,
  input  pipe_slot_t                wb_i,
  output logic [1:0]                sel_o
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = slot_writes_reg(mem_i) & (mem_i.rd == src_i);
  assign wb_hit  = slot_writes_reg(wb_i)  & (wb_i.rd  == src_i);

  always_comb begin
    // NOTE: default first so every path assigns sel_o and no latch is inferred.
    sel_o = FWD_REGFILE;
    if (ex_valid_i) begin
      // MEM is checked before WB: the youngest producer holds the newest value.
      if (mem_hit) begin
        sel_o = FWD_EXMEM;
      end else if (wb_hit) begin
        sel_o = FWD_MEMWB;
      end
    end
  end

endmodule : fwd_sel

// File: rtl/hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// hazard_fwd_unit
//
// Data-hazard unit for a classic 5-stage pipeline. It shadows the destination
// tags of in-flight instructions through EX, MEM and WB, drives the two
// EX-stage operand-forwarding selects, and detects the load-use case that
// forwarding cannot cover, stalling PC/IF-ID for one cycle while a bubble is
// pushed into EX.
//
// Parameters:
//   REG_AW  register-address width; the slot types in hazard_pkg are sized by
//           REG_AW_DEFAULT, so an override must be matched there
//   CNT_W   stall-counter width (present only with HAZ_STALL_CNT_EN)
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous reset, active-high; clears every slot valid bit
//   id_valid_i     ID holds a real instruction
//   id_rs_i        ID source register 1
//   id_rt_i        ID source register 2
//   id_rd_i        ID destination register (already rt/rd muxed)
//   id_regwrite_i  ID instruction writes the register file
//   id_memread_i   ID instruction is a load
//   flush_i        taken branch/jump: the ID instruction is discarded
//   fwd_a_o        operand-A select for EX
//   fwd_b_o        operand-B select for EX
//   stall_o        load-use stall this cycle
//   pc_write_o     PC write enable (~stall_o)
//   ifid_write_o   IF/ID write enable (~stall_o)
//   stall_cnt_o    saturating count of stall cycles (HAZ_STALL_CNT_EN only)
//
// Build option:
//   HAZ_STALL_CNT_EN  adds the CNT_W parameter, stall_cnt_o and its counter.
// -----------------------------------------------------------------------------
module hazard_fwd_unit
  import hazard_pkg::*;
#(
`ifdef HAZ_STALL_CNT_EN
  parameter int CNT_W  = CNT_W_DEFAULT,
`endif
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
`ifdef HAZ_STALL_CNT_EN
  output logic [CNT_W-1:0]  stall_cnt_o,
`endif
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              stall_o,
  output logic              pc_write_o,
  output logic              ifid_write_o
);

  ex_slot_t   ex_q,  ex_d;
  pipe_slot_t mem_q, mem_d;
  pipe_slot_t wb_q,  wb_d;

  logic load_use;
  logic ex_capture;

  // ---------------------------------------------------------------------------
  // Load-use detection. A load in EX only has its data at the end of MEM, so a
  // consumer in ID must wait one cycle; after that the load is in MEM, the
  // consumer enters EX a cycle later and picks the data up from WB.
  // A flushed ID instruction is being thrown away, so it never stalls.
  // ---------------------------------------------------------------------------
  assign load_use = ex_q.valid & ex_q.memread & (ex_q.rd != '0) &
                    id_valid_i & ~flush_i &
                    ((ex_q.rd == id_rs_i) | (ex_q.rd == id_rt_i));

  assign stall_o      = load_use;
  assign pc_write_o   = ~load_use;
  assign ifid_write_o = ~load_use;

  // ---------------------------------------------------------------------------
  // Next-slot contents. EX takes the ID instruction only when it really
  // advances; a stall or flush turns EX into a bubble. MEM and WB always shift.
  // ---------------------------------------------------------------------------
  assign ex_capture = id_valid_i & ~load_use & ~flush_i;

  always_comb begin
    ex_d          = '0;
    ex_d.valid    = ex_capture;
    ex_d.rs       = id_rs_i;
    ex_d.rt       = id_rt_i;
    ex_d.rd       = id_rd_i;
    ex_d.regwrite = id_regwrite_i;
    ex_d.memread  = id_memread_i;
  end

  always_comb begin
    mem_d          = '0;
    mem_d.valid    = ex_q.valid;
    mem_d.rd       = ex_q.rd;
    mem_d.regwrite = ex_q.regwrite;
  end

  assign wb_d = mem_q;

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every slot samples the pre-edge value
    // of its neighbour, giving a true shift register regardless of order.
    ex_q  <= ex_d;
    mem_q <= mem_d;
    wb_q  <= wb_d;
    if (rst_i) begin
      // NOTE: only valid bits are reset; tags and flags are qualified by valid
      // everywhere, so leaving them unreset saves reset fan-out without risk.
      ex_q.valid  <= 1'b0;
      mem_q.valid <= 1'b0;
      wb_q.valid  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding selects: one compare-and-prioritise block per operand. They
  // look at slot registers only, so they are stable early in the EX cycle.
  // ---------------------------------------------------------------------------
  fwd_sel u_fwd_sel_a (
    .ex_valid_i (ex_q.valid),
    .src_i      (ex_q.rs),
    .mem_i      (mem_q),
    .wb_i       (wb_q),
    .sel_o      (fwd_a_o)
  );

  fwd_sel u_fwd_sel_b (
    .ex_valid_i (ex_q.valid),
    .src_i      (ex_q.rt),
    .mem_i      (mem_q),
    .wb_i       (wb_q),
    .sel_o      (fwd_b_o)
  );

`ifdef HAZ_STALL_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating stall counter for performance monitoring.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (load_use && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule : hazard_fwd_unit
